da_lut_ctrl: RTL

Sequencing controller for the distributed-arithmetic LUT datapath. It accepts one vector of K signed activations, then drives the LUT address bus bit-serially, one bit-plane per cycle, MSB first. It shift-accumulates the returned partial sums into the exact dot product Σ B_i·x_i and hands the result downstream with valid/ready. It sits between the activation source and the LUT, and is gated by the LUT-loaded flag (`gen_done`) from the weight generator.

---
 rtl/da_ctrl_pkg.sv | 23 ++
 rtl/da_tag_pipe.sv | 53 +++++
 rtl/da_lut_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/da_ctrl_pkg.sv
// Shared types and width helpers for the distributed-arithmetic LUT controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package da_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // LUT word: a sum of up to k weights needs log2(k) growth bits plus sign headroom.
    function automatic int lut_w(input int k, input int dwb);
        return dwb + $clog2(k) + 1;
    endfunction

    // Accumulator: LUT word scaled by the full activation range.
    function automatic int acc_w(input int k, input int dwa, input int dwb);
        return lut_w(k, dwb) + dwa;
    endfunction

endpackage

// File: rtl/da_tag_pipe.sv
// Delay line carrying {valid, is_msb} alongside each outstanding LUT read.
// Latency: DEPTH cycles from vld_in/msb_in to vld_out/msb_out.
// Backpressure: none; shifts every cycle, async clear drops all in-flight tags.
module da_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_in,
    input  logic msb_in,
    output logic vld_out,
    output logic msb_out,
    output logic rest_vld
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] msb_q, msb_d;

    // Shift the tags one stage per cycle; stage 0 captures the read issued this cycle.
    always_comb begin
        vld_d    = vld_q;
        msb_d    = msb_q;
        vld_d[0] = vld_in;
        msb_d[0] = msb_in;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            msb_d[i] = msb_q[i-1];
        end
    end

    // Any read still in flight behind the one returning now.
    always_comb begin
        rest_vld = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            rest_vld = rest_vld | vld_q[i];
        end
    end

    // Tag registers; reset discards every outstanding read so nothing stale is accumulated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            msb_q <= '0;
        end else begin
            vld_q <= vld_d;
            msb_q <= msb_d;
        end
    end

    assign vld_out = vld_q[DEPTH-1];
    assign msb_out = msb_q[DEPTH-1];

endmodule

// File: rtl/da_lut_ctrl.sv
// Bit-serial DA sequencer: walks activation bit-planes MSB first into the LUT and shift-accumulates Σ B_i·x_i.
// Latency: result valid DATA_WIDTH_A+LUT_LAT edges after acceptance; one vector per DATA_WIDTH_A+LUT_LAT+2 cycles.
// Backpressure: result held in OUT until y_ready; no new vector accepted until back in IDLE with gen_done high.
module da_lut_ctrl
    import da_ctrl_pkg::*;
#(
    parameter int K            = 32,
    parameter int DATA_WIDTH_A = 8,
    parameter int DATA_WIDTH_B = 16,
    parameter int LUT_LAT      = 1,
    localparam int LW          = lut_w(K, DATA_WIDTH_B),
    localparam int ACC_W       = acc_w(K, DATA_WIDTH_A, DATA_WIDTH_B)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               gen_done,
    input  logic                               x_valid,
    output logic                               x_ready,
    input  logic [K-1:0][DATA_WIDTH_A-1:0]     x_data,
    output logic                               lut_rd,
    output logic [K-1:0]                       lut_addr,
    input  logic signed [LW-1:0]               lut_data,
    output logic                               y_valid,
    output logic signed [ACC_W-1:0]            y_data,
    input  logic                               y_ready,
    output logic                               busy
);

    localparam int CW = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
    localparam logic [CW-1:0] MSB_BIT = CW'(DATA_WIDTH_A - 1);

    state_t                           state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [K-1:0][DATA_WIDTH_A-1:0]   x_q, x_d;
    logic                             lut_rd_q, lut_rd_d;
    logic [K-1:0]                     lut_addr_q, lut_addr_d;
    logic                             y_valid_q, y_valid_d;
    logic                             busy_q, busy_d;
    logic signed [ACC_W-1:0]          acc_q, acc_d;
    logic signed [ACC_W-1:0]          ret_ext;
    logic                             tag_vld, tag_msb, tag_rest;

    // Only IDLE with a loaded LUT can take a vector; gen_done is not watched afterwards.
    assign x_ready = (state_q == IDLE) && gen_done;

    assign ret_ext = {{(ACC_W - LW){lut_data[LW-1]}}, lut_data};

    // Each read's tag marks whether it is the sign-weighted MSB plane.
    da_tag_pipe #(
        .DEPTH (LUT_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (lut_rd_q),
        .msb_in   (lut_rd_q && (cnt_q == MSB_BIT)),
        .vld_out  (tag_vld),
        .msb_out  (tag_msb),
        .rest_vld (tag_rest)
    );

    // Next-state, accumulator update and registered-output preparation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        acc_d      = acc_q;
        lut_addr_d = '0;

        case (state_q)
            IDLE: begin
                if (x_valid && x_ready) begin
                    x_d     = x_data;
                    cnt_d   = MSB_BIT;
                    acc_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DRAIN: begin
                // Last read is returning now and nothing is queued behind it.
                if (tag_vld && !tag_rest) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (y_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // MSB plane carries negative weight in two's complement; later planes shift in.
        if (tag_vld) begin
            if (tag_msb) begin
                acc_d = -ret_ext;
            end else begin
                acc_d = (acc_q <<< 1) + ret_ext;
            end
        end

        lut_rd_d  = (state_d == ISSUE);
        y_valid_d = (state_d == OUT);
        busy_d    = (state_d != IDLE);
        if (lut_rd_d) begin
            for (int i = 0; i < K; i++) begin
                lut_addr_d[i] = x_d[i][cnt_d];
            end
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            acc_q      <= '0;
            lut_rd_q   <= 1'b0;
            lut_addr_q <= '0;
            y_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            acc_q      <= acc_d;
            lut_rd_q   <= lut_rd_d;
            lut_addr_q <= lut_addr_d;
            y_valid_q  <= y_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign lut_rd   = lut_rd_q;
    assign lut_addr = lut_addr_q;
    assign y_valid  = y_valid_q;
    assign y_data   = acc_q;
    assign busy     = busy_q;

endmodule
